// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: frame-based signed sum of Booth products with overflow detection.
// Define BOOTH_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_product_accumulator #(
    parameter int ACC_W = 13
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [3:0]              i_count,
    input  logic                    i_clear,
    input  logic                    i_prod_valid,
    input  logic signed [8:0]       i_product,
    output logic                    o_prod_ready,
    output logic                    o_acc_valid,
    output logic signed [ACC_W-1:0] o_acc_out,
    input  logic                    i_acc_ready,
    output logic                    o_overflow,
    output logic                    o_busy
);
    typedef enum logic [2:0] {IDLE = 3'b001, ACCUM = 3'b010, DONE = 3'b100} state_t;
    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt, w_add_res;
    logic [4:0]              r_rem, w_rem_nxt;
    logic                    r_ovf, w_ovf_nxt;
    logic [ACC_W:0]          w_sum;
    logic                    w_add_ovf, w_xfer;
    // One guard bit holds the exact sum; guard and sign disagree exactly on overflow.
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-8){i_product[8]}}, i_product};
    assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef BOOTH_ACC_SATURATE_EN
    assign w_add_res = !w_add_ovf ? w_sum[ACC_W-1:0] :
                       w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_add_res = w_sum[ACC_W-1:0];
`endif
    assign o_prod_ready = (r_state == ACCUM);
    assign o_acc_valid  = (r_state == DONE);
    assign o_busy       = (r_state != IDLE);
    assign o_acc_out    = r_acc;
    assign o_overflow   = r_ovf;
    assign w_xfer       = i_prod_valid & o_prod_ready;
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_ovf_nxt   = r_ovf;
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_rem_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    w_state_nxt = ACCUM;
                    w_acc_nxt   = '0;
                    w_rem_nxt   = (i_count == 4'd0) ? 5'd16 : {1'b0, i_count};
                    w_ovf_nxt   = 1'b0;
                end
                ACCUM: if (w_xfer) begin
                    w_acc_nxt   = w_add_res;
                    w_ovf_nxt   = r_ovf | w_add_ovf;
                    w_rem_nxt   = r_rem - 5'd1;
                    w_state_nxt = (r_rem == 5'd1) ? DONE : ACCUM;
                end
                DONE: w_state_nxt = i_acc_ready ? IDLE : DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end
endmodule

// File: doc/booth_product_accumulator.md
BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 13: accumulator and result width in bits, signed, legal range 10..24.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_start, input, 1 bit: frame start pulse.
REQ-005 SHALL have port i_count, input, 4 bits: products per frame, sampled on start; 0 means 16.
REQ-006 SHALL have port i_clear, input, 1 bit: synchronous abort.
REQ-007 SHALL have port i_prod_valid, input, 1 bit: upstream product valid.
REQ-008 SHALL have port i_product, input, 9 bits: signed two's-complement product from the Booth multiplier.
REQ-009 SHALL have port o_prod_ready, output, 1 bit: product accept.
REQ-010 SHALL have port o_acc_valid, output, 1 bit: frame result valid.
REQ-011 SHALL have port o_acc_out, output, ACC_W bits: signed frame sum.
REQ-012 SHALL have port i_acc_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port o_overflow, output, 1 bit: frame overflow flag, valid while o_acc_valid=1.
REQ-014 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement a registered one-hot FSM with states IDLE, ACCUM and DONE.
REQ-016 IDLE SHALL hold o_prod_ready=0 and o_acc_valid=0; i_start=1 SHALL load remaining=(i_count==0 ? 16 : i_count), clear the accumulator and the overflow flag, and move to ACCUM.
REQ-017 ACCUM SHALL drive o_prod_ready=1; a transfer occurs on a cycle where i_prod_valid=1 and o_prod_ready=1.
REQ-018 On each transfer, acc SHALL become acc + sign-extend(i_product) and remaining SHALL decrement by 1.
REQ-019 A transfer with remaining==1 SHALL move the FSM to DONE on the next edge; o_acc_valid SHALL rise one cycle after the last transfer.
REQ-020 DONE SHALL hold o_acc_valid=1 with o_acc_out and o_overflow stable, and o_prod_ready=0, until i_acc_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-021 o_acc_out SHALL be driven from the accumulator register, not combinationally from i_product.
REQ-022 i_start SHALL be ignored in ACCUM and DONE.
REQ-023 i_clear=1 SHALL, in any state, force IDLE, accumulator=0 and overflow=0 on the next edge.
REQ-024 i_clear SHALL win over i_start, over a transfer and over i_acc_ready when they occur in the same cycle.
REQ-025 Overflow SHALL be detected when the exact sum lies outside the signed range of ACC_W; once set, o_overflow SHALL stay set until the next start or clear.
REQ-026 i_product values outside -64..+64 SHALL still be accumulated arithmetically, with no range check.
REQ-027 Gaps in i_prod_valid during ACCUM SHALL leave the accumulator and remaining unchanged.

Reset
REQ-028 i_rst=0 SHALL asynchronously force IDLE, accumulator=0, remaining=0 and overflow=0.
REQ-029 During reset, o_prod_ready, o_acc_valid, o_overflow and o_busy SHALL be 0 and o_acc_out SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no output.
REQ-031 Reset deassertion SHALL take effect on the next i_clk edge.

Configuration
REQ-032 Macro BOOTH_ACC_SATURATE_EN, when defined, SHALL make any overflowing addition clamp the accumulator to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set overflow.
REQ-033 Without BOOTH_ACC_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_W and set overflow.

Verification
REQ-034 Scenario: start, i_count=4, products 6, -12, 49, -8 with no gaps, i_acc_ready=1 -> o_acc_valid one cycle after the 4th product, o_acc_out=35, o_overflow=0, then IDLE.
REQ-035 Scenario: i_count=0, sixteen products of 64, ACC_W=13 -> o_acc_out=1024, o_overflow=0.
REQ-036 Scenario: ACC_W=10, i_count=9, nine products of 64 (sum 576) -> with the macro o_acc_out=511 and o_overflow=1; without it o_acc_out=-448 and o_overflow=1.
REQ-037 Scenario: i_acc_ready held 0 for 5 cycles in DONE -> o_acc_valid and o_acc_out stable for 5 cycles, and a start pulse in that window is ignored.
REQ-038 Scenario: clear asserted together with the 2nd of 3 transfers -> next cycle IDLE, o_busy=0, no o_acc_valid pulse; a new frame of 3 products of 1 returns 3.
REQ-039 Scenario: reset pulsed mid-ACCUM with valid gaps -> all outputs 0 asynchronously, and a subsequent frame sums correctly.
